// File: rtl/async_evt_pkg.sv
// rtl/async_evt_pkg.sv - shared types and constants for the async event arbiter
package async_evt_pkg;

   typedef enum logic {
      EVT_IDLE  = 1'b0,
      EVT_OFFER = 1'b1
   } evt_state_e;

   localparam int                  DROP_CNT_W   = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/ff_sync.sv
// rtl/ff_sync.sv - two-flop synchronizer bank, asynchronous active-high reset
module ff_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/async_evt_arbiter.sv
// rtl/async_evt_arbiter.sv - async rising-edge event capture with round-robin valid/ready delivery
// Optional saturating drop counter enabled by ASYNC_EVT_ARBITER_DROP_CNT_EN.
module async_evt_arbiter
   import async_evt_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_async,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [IDX_W-1:0]      evt_idx,
   output logic [N_REQ-1:0]      pending,
   output logic                  drop_sticky,
   input  logic                  drop_clr,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   // First set bit of p searching upward from last+1, wrapping to 0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                                input logic [IDX_W-1:0] last);
      logic found;
      int   j;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(last) + k) % N_REQ;
         if (!found && p[j]) begin
            rr_pick = IDX_W'(j);
            found   = 1'b1;
         end
      end
   endfunction

   logic             sync_rst;
   logic [N_REQ-1:0] req_s;
   logic [N_REQ-1:0] hist_q;
   logic [N_REQ-1:0] rise;
   logic [N_REQ-1:0] clr_vec;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic             any_drop;
   logic             handshake;
   logic             sticky_q, sticky_d;
   evt_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;

   assign sync_rst = ~rst_n;

   ff_sync #(.WIDTH(N_REQ)) u_sync (
      .clk_i (clk),
      .rst_i (sync_rst),
      .d_i   (req_async),
      .q_o   (req_s)
   );

   assign rise      = req_s & ~hist_q;
   assign handshake = (state_q == EVT_OFFER) & evt_ready;
   assign clr_vec   = handshake ? (N_REQ'(1) << idx_q) : '0;

   // A rise coinciding with its own line's handshake re-queues rather than drops.
   assign pending_d = (pending_q & ~clr_vec) | rise;
   assign any_drop  = |(rise & pending_q & ~clr_vec);

   always_comb begin
      sticky_d = sticky_q | any_drop;
      if (drop_clr) begin
         sticky_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      case (state_q)
         EVT_IDLE: begin
            if (|pending_q) begin
               idx_d   = rr_pick(pending_q, last_q);
               state_d = EVT_OFFER;
            end
         end
         EVT_OFFER: begin
            if (evt_ready) begin
               last_d  = idx_q;
               state_d = EVT_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q    <= '0;
         pending_q <= '0;
         sticky_q  <= 1'b0;
         state_q   <= EVT_IDLE;
         idx_q     <= '0;
         last_q    <= IDX_W'(N_REQ - 1);
      end else begin
         hist_q    <= req_s;
         pending_q <= pending_d;
         sticky_q  <= sticky_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
      end
   end

   assign evt_valid   = (state_q == EVT_OFFER);
   assign evt_idx     = idx_q;
   assign pending     = pending_q;
   assign drop_sticky = sticky_q;

`ifdef ASYNC_EVT_ARBITER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_clr) begin
         drop_cnt_d = '0;
      end else if (any_drop && (drop_cnt_q != DROP_CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

endmodule
